// File: rtl/wide_and_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wide_and_sequencer_pkg
// Purpose  : Shared state encoding and sizing helpers for the wide AND
//            sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package wide_and_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIN  = 2'd2
    } seq_state_t;

    // ceil(log2(v)) with a floor of 1 so degenerate counters still get a bit
    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int calc_nchunk(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

    function automatic int calc_nscan_w(input int nchunk);
        return clog2_min1(nchunk + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wide_and_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : wide_and_sequencer_if
// Purpose  : Start/done request bus between a requester and the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface wide_and_sequencer_if #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
);
    import wide_and_sequencer_pkg::*;

    localparam int NSCAN_W = calc_nscan_w(calc_nchunk(WIDTH, CHUNK));

    logic               start;
    logic [WIDTH-1:0]   din;
    logic               busy;
    logic               done;
    logic               out;
    logic [NSCAN_W-1:0] nscan;

    modport master (
        output start, din,
        input  busy, done, out, nscan
    );

    modport slave (
        input  start, din,
        output busy, done, out, nscan
    );

endinterface
`default_nettype wire

// File: rtl/wide_and_sequencer_carry_and.sv
`default_nettype none
// ============================================================================
// Module   : wide_and_sequencer_carry_and
// Purpose  : Combinational AND-reduction of one slice, implementation
//            selectable through METHOD.
// Revision : 1.0 - initial release
// ============================================================================
module wide_and_sequencer_carry_and #(
    parameter int WIDTH  = 16,
    parameter int METHOD = 0
) (
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_and
);

    generate
        if (METHOD == 1) begin : g_ripple
            logic w_chain;
            always_comb begin
                w_chain = 1'b1;
                for (int i = 0; i < WIDTH; i++) begin
                    w_chain = w_chain & i_data[i];
                end
            end
            assign o_and = w_chain;
        end else if (METHOD == 2) begin : g_split
            if (WIDTH == 1) begin : g_single
                assign o_and = i_data[0];
            end else begin : g_halves
                localparam int LO_W = WIDTH / 2;
                assign o_and = (&i_data[LO_W-1:0]) & (&i_data[WIDTH-1:LO_W]);
            end
        end else if (METHOD == 3) begin : g_demorgan
            assign o_and = ~|(~i_data);
        end else if (METHOD == 4) begin : g_compare
            assign o_and = (i_data == {WIDTH{1'b1}});
        end else begin : g_reduce
            assign o_and = &i_data;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wide_and_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : wide_and_sequencer
// Purpose  : Multi-cycle wide AND-reduction, one CHUNK-bit slice per cycle
//            through a shared reducer, least significant slice first.
// Revision : 1.0 - initial release
// ============================================================================
module wide_and_sequencer #(
    parameter int WIDTH      = 64,
    parameter int CHUNK      = 16,
    parameter int METHOD     = 0,
    parameter int EARLY_EXIT = 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    wide_and_sequencer_if.slave  bus
);
    import wide_and_sequencer_pkg::*;

    localparam int NCHUNK  = calc_nchunk(WIDTH, CHUNK);
    localparam int IDX_W   = clog2_min1(NCHUNK);
    localparam int NSCAN_W = calc_nscan_w(NCHUNK);
    localparam int PAD_W   = NCHUNK * CHUNK;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    seq_state_t         state_q, state_d;
    logic [WIDTH-1:0]   op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               acc_q, acc_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               out_q, out_d;
    logic [NSCAN_W-1:0] nscan_q, nscan_d;

    logic [PAD_W-1:0]   w_op_pad;
    logic [CHUNK-1:0]   w_slice;
    logic               w_red;

    // Pad with ones so a partial top slice cannot force the result low
    generate
        if (PAD_W > WIDTH) begin : g_pad
            assign w_op_pad = {{(PAD_W - WIDTH){1'b1}}, op_q};
        end else begin : g_nopad
            assign w_op_pad = op_q;
        end
    endgenerate

    always_comb begin
        w_slice = w_op_pad[CHUNK-1:0];
        for (int i = 1; i < NCHUNK; i++) begin
            if (idx_q == IDX_W'(i)) begin
                w_slice = w_op_pad[i*CHUNK +: CHUNK];
            end
        end
    end

    wide_and_sequencer_carry_and #(
        .WIDTH  (CHUNK),
        .METHOD (METHOD)
    ) u_carry_and (
        .i_data (w_slice),
        .o_and  (w_red)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        nscan_d = nscan_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.din;
                    acc_d   = 1'b1;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                acc_d = acc_q & w_red;
                if ((idx_q == LAST_IDX) || ((EARLY_EXIT != 0) && !w_red)) begin
                    busy_d  = 1'b0;
                    state_d = ST_FIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_FIN: begin
                out_d   = acc_q;
                nscan_d = NSCAN_W'(idx_q) + NSCAN_W'(1);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            idx_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= 1'b0;
            nscan_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            nscan_q <= nscan_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.out   = out_q;
    assign bus.nscan = nscan_q;

endmodule
`default_nettype wire

// File: tb/tb_wide_and_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_wide_and_sequencer
// Purpose  : Scoreboard bench driving several sequencer configurations in
//            lockstep from one request stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wide_and_sequencer;

    localparam int NDUT = 5;
    localparam int P_W [NDUT] = '{64, 64, 40, 33, 12};
    localparam int P_C [NDUT] = '{16, 16, 16,  8, 12};
    localparam int P_M [NDUT] = '{ 0,  1,  2,  3,  4};
    localparam int P_E [NDUT] = '{ 1,  0,  1,  0,  1};

    typedef struct {
        bit out;
        int s;
        int edge_no;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [63:0]     din;
    logic [NDUT-1:0] idle_v;
    bit              chk_en;
    int              n_checks;
    int              n_fail;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic bit model_and(input logic [63:0] d, input int w);
        bit r;
        r = 1'b1;
        for (int b = 0; b < w; b++) if (!d[b]) r = 1'b0;
        return r;
    endfunction

    function automatic int model_scans(input logic [63:0] d, input int w, input int c, input int ee);
        int n;
        bit z;
        n = (w + c - 1) / c;
        if (ee == 0) return n;
        for (int j = 0; j < n; j++) begin
            z = 1'b1;
            for (int b = j * c; b < (j + 1) * c; b++) begin
                if (b < w && !d[b]) z = 1'b0;
            end
            if (!z) return j + 1;
        end
        return n;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : g_inst
        localparam int W = P_W[g];
        localparam int C = P_C[g];

        wide_and_sequencer_if #(.WIDTH(W), .CHUNK(C)) bus_if ();

        wide_and_sequencer #(
            .WIDTH      (W),
            .CHUNK      (C),
            .METHOD     (P_M[g]),
            .EARLY_EXIT (P_E[g])
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus_if.slave)
        );

        assign bus_if.start = start;
        assign bus_if.din   = din[W-1:0];

        exp_t q[$];
        int   cnt = 0;
        int   edge_no = 0;
        bit   last_out = 1'b0;
        int   last_nscan = 0;

        assign idle_v[g] = (cnt == 0);

        // Cycle model: accept only when idle, then stay unavailable for S+1 edges
        always @(posedge clk) begin
            exp_t e;
            edge_no++;
            if (rst) begin
                q.delete();
                cnt        = 0;
                last_out   = 1'b0;
                last_nscan = 0;
            end else if (cnt == 0) begin
                if (start) begin
                    e.out     = model_and(din, W);
                    e.s       = model_scans(din, W, C, P_E[g]);
                    e.edge_no = edge_no;
                    q.push_back(e);
                    cnt = e.s + 1;
                end
            end else begin
                cnt--;
            end
        end

        always @(negedge clk) begin
            bit   exp_done;
            exp_t e;
            if (chk_en) begin
                exp_done = (q.size() > 0) && (edge_no == q[0].edge_no + q[0].s + 1);
                check_eq($sformatf("dut%0d done", g), 64'(bus_if.done), 64'(exp_done));
                if (exp_done) begin
                    e          = q.pop_front();
                    last_out   = e.out;
                    last_nscan = e.s;
                end
                check_eq($sformatf("dut%0d busy", g), 64'(bus_if.busy), 64'(cnt >= 2));
                check_eq($sformatf("dut%0d out", g), 64'(bus_if.out), 64'(last_out));
                check_eq($sformatf("dut%0d nscan", g), 64'(bus_if.nscan), 64'(last_nscan));
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (!(&idle_v) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("idle timeout", 64'(&idle_v), 64'd1);
    endtask

    task automatic pulse(input logic [63:0] d);
        wait_idle();
        start = 1'b1;
        din   = d;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle();
    endtask

    initial begin
        int          fails0;
        int          r;
        logic [63:0] d;
        rst      = 1'b1;
        start    = 1'b0;
        din      = '0;
        chk_en   = 1'b0;
        n_checks = 0;
        n_fail   = 0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;

        pulse('1);
        pulse(~(64'h1 << 37));
        pulse(~(64'h1 << 39));
        pulse(~(64'h1 << 5));
        pulse('1);

        // Held start with a changing operand: one accept per idle window
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            din = (i % 2 == 1) ? '1 : ~(64'h1 << (i * 7));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_idle();

        // Abort in the second scan cycle after a result of 1
        pulse('1);
        start = 1'b1;
        din   = '1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        pulse('1);

        fails0 = n_fail;
        for (int n = 0; n < 1000; n++) begin
            r = $urandom_range(0, 3);
            d = {$urandom, $urandom};
            if (r < 2) begin
                d = '1;
            end else if (r == 2) begin
                d = '1;
                d[$urandom_range(0, 63)] = 1'b0;
            end
            pulse(d);
        end
        if (n_fail == fails0) $display("random test PASS");

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
